// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois PRBS generator/checker pair.
package lfsr_pkg;

    // Feedback taps of x^8+x^4+x^3+x^2+1 (bit i = coefficient of x^i, x^8 implied).
    localparam logic [7:0] LFSR8_TAPS = 8'h1D;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } lfsr_state_t;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
    endfunction

    // hist[k] holds the bit seen k+1 beats ago, so tap x^i lands on hist[7-i].
    localparam logic [7:0] PRED_MASK = rev8(LFSR8_TAPS);

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] cnt
);

    // Clear wins over the stored value but still records a same-cycle increment.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? ERR_W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ERR_W'(1);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the 8-bit Galois LFSR stream.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_LIM = 8'(UNLOCK_CNT);

    lfsr_state_t state, state_nxt;
    logic [7:0]  hist, hist_nxt;
    logic [2:0]  fill_cnt, fill_nxt;
    logic [7:0]  run_cnt, run_nxt;
    logic [7:0]  run_inc;
    logic        pred;
    logic        match;
    logic        hist_live;
    logic        err_hit;

    assign pred      = ^(hist & PRED_MASK);
    assign match     = (bit_in == pred);
    assign hist_live = |hist;
    assign run_inc   = run_cnt + 8'd1;

    // Next-state: history shift, fill/hunt/locked sequencing and error detection.
    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill_cnt;
        run_nxt   = run_cnt;
        err_hit   = 1'b0;
        if (bit_valid) begin
            hist_nxt = {hist[6:0], bit_in};
            case (state)
                ST_FILL: begin
                    if (fill_cnt == 3'd7) begin
                        state_nxt = ST_HUNT;
                        fill_nxt  = '0;
                        run_nxt   = '0;
                    end else begin
                        fill_nxt = fill_cnt + 3'd1;
                    end
                end
                ST_HUNT: begin
                    if (match && hist_live) begin
                        if (run_inc == LOCK_LIM) begin
                            state_nxt = ST_LOCKED;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    // An all-zero history cannot occur in the m-sequence: resync silently.
                    if (!hist_live) begin
                        state_nxt = ST_FILL;
                        fill_nxt  = '0;
                        run_nxt   = '0;
                    end else if (!match) begin
                        err_hit = 1'b1;
                        if (run_inc == UNLOCK_LIM) begin
                            state_nxt = ST_FILL;
                            fill_nxt  = '0;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_FILL;
                    fill_nxt  = '0;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    // State and output registers; locked tracks the state being entered.
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= ST_FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            hist      <= hist_nxt;
            fill_cnt  <= fill_nxt;
            run_cnt   <= run_nxt;
            locked    <= (state_nxt == ST_LOCKED);
            err_pulse <= err_hit;
        end
    end

    sat_counter #(
        .ERR_W(ERR_W)
    ) u_err_cnt (
        .clk(clk),
        .res(res),
        .clr(err_clr),
        .inc(err_hit),
        .cnt(err_cnt)
    );

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: Galois generator source, queue-based reference model,
// vector table for reset plus directed multi-cycle sequences and random traffic.
module tb_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res, bit_valid, bit_in, err_clr;
    logic        locked_a, err_pulse_a;
    logic [15:0] err_cnt_a;
    logic        locked_b, err_pulse_b;
    logic [3:0]  err_cnt_b;

    lfsr_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_W(16)) dut_a (
        .clk(clk), .res(res), .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_cnt(err_cnt_a)
    );

    lfsr_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_W(4)) dut_b (
        .clk(clk), .res(res), .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_cnt(err_cnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Generator: Galois LFSR, serial output is the MSB of the current state.
    logic [7:0] gen = 8'h01;
    task automatic gen_next(output logic b);
        b   = gen[7];
        gen = {gen[6:0], 1'b0} ^ (gen[7] ? 8'h1D : 8'h00);
    endtask

    // Reference model: queue of received bits (newest first) and the lock rules.
    localparam int M_FILL = 0, M_HUNT = 1, M_LOCKED = 2;
    localparam int LOCK_N = 16, UNLOCK_N = 4;
    bit rx[$];
    int m_mode, m_filled, m_run, m_cnt_a, m_cnt_b;
    bit m_locked, m_pulse;

    function automatic void model_reset();
        rx.delete();
        for (int i = 0; i < 8; i++) rx.push_front(1'b0);
        m_mode = M_FILL; m_filled = 0; m_run = 0;
        m_cnt_a = 0; m_cnt_b = 0; m_locked = 1'b0; m_pulse = 1'b0;
    endfunction

    function automatic void model_step(input bit r, input bit v, input bit b, input bit c);
        bit counted;
        bit pred;
        bit all_zero;
        counted = 1'b0;
        if (r) begin
            model_reset();
            return;
        end
        if (v) begin
            // s[n] = s[n-4] ^ s[n-5] ^ s[n-6] ^ s[n-8]
            pred = rx[3] ^ rx[4] ^ rx[5] ^ rx[7];
            all_zero = 1'b1;
            foreach (rx[k]) if (rx[k]) all_zero = 1'b0;
            if (m_mode == M_FILL) begin
                m_filled++;
                if (m_filled == 8) begin m_mode = M_HUNT; m_filled = 0; m_run = 0; end
            end else if (m_mode == M_HUNT) begin
                if (b == pred && !all_zero) begin
                    m_run++;
                    if (m_run == LOCK_N) begin m_mode = M_LOCKED; m_run = 0; end
                end else m_run = 0;
            end else begin
                if (all_zero) begin
                    m_mode = M_FILL; m_filled = 0; m_run = 0;
                end else if (b != pred) begin
                    counted = 1'b1;
                    m_run++;
                    if (m_run == UNLOCK_N) begin m_mode = M_FILL; m_filled = 0; m_run = 0; end
                end else m_run = 0;
            end
            rx.push_front(b);
            void'(rx.pop_back());
        end
        m_pulse = counted;
        if (c) begin
            m_cnt_a = int'(counted);
            m_cnt_b = int'(counted);
        end else if (counted) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 15) m_cnt_b++;
        end
        m_locked = (m_mode == M_LOCKED);
    endfunction

    task automatic step(input logic r, input logic v, input logic b, input logic c);
        res = r; bit_valid = v; bit_in = b; err_clr = c;
        @(posedge clk);
        model_step(r, v, b, c);
        #1;
        check("locked",      32'(locked_a),    32'(m_locked));
        check("err_pulse",   32'(err_pulse_a), 32'(m_pulse));
        check("err_cnt",     32'(err_cnt_a),   32'(m_cnt_a));
        check("locked_w4",   32'(locked_b),    32'(m_locked));
        check("err_pulse_w4",32'(err_pulse_b), 32'(m_pulse));
        check("err_cnt_w4",  32'(err_cnt_b),   32'(m_cnt_b));
    endtask

    task automatic clean_beat(input bit flip, input bit clr);
        logic b;
        gen_next(b);
        step(1'b0, 1'b1, b ^ flip, clr);
    endtask

    typedef struct {
        logic        r, v, b, c;
        logic        exp_locked, exp_pulse;
        logic [15:0] exp_cnt;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   lock_beat, mask, pulses, fell, beats, valid_beats;

        res = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; err_clr = 1'b0;
        model_reset();

        // 1. Reset held with random traffic on the other inputs.
        foreach (vecs[i]) begin
            vecs[i].r = 1'b1;
            vecs[i].v = 1'($urandom);
            vecs[i].b = 1'($urandom);
            vecs[i].c = 1'($urandom);
            vecs[i].exp_locked = 1'b0;
            vecs[i].exp_pulse  = 1'b0;
            vecs[i].exp_cnt    = 16'd0;
        end
        for (int i = 0; i < 4; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].b, vecs[i].c);
            check("rst_locked", 32'(locked_a),    32'(vecs[i].exp_locked));
            check("rst_pulse",  32'(err_pulse_a), 32'(vecs[i].exp_pulse));
            check("rst_cnt",    32'(err_cnt_a),   32'(vecs[i].exp_cnt));
        end

        // 2. Clean continuous stream: lock after 24 beats, no errors afterwards.
        gen = 8'h01;
        lock_beat = 0;
        for (int i = 1; i <= 2000; i++) begin
            clean_beat(1'b0, 1'b0);
            if (locked_a && lock_beat == 0) lock_beat = i;
        end
        check("lock_beat", 32'(lock_beat), 32'd24);
        check("clean_cnt", 32'(err_cnt_a), 32'd0);

        // 3. One inverted bit: errors at offsets 0,4,5,6,8.
        mask = 0;
        for (int j = 0; j < 20; j++) begin
            clean_beat(j == 0, 1'b0);
            if (err_pulse_a) mask |= (1 << j);
        end
        check("flip_mask",   32'(mask),      32'h171);
        check("flip_cnt",    32'(err_cnt_a), 32'd5);
        check("flip_locked", 32'(locked_a),  32'd1);

        // 4. Stuck at one: drops lock, then relocks after 24 clean beats.
        pulses = 0; fell = 0;
        for (int j = 0; j < 40 && !fell; j++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (err_pulse_a) pulses++;
            if (!locked_a) fell = 1;
        end
        check("ones_unlock", 32'(fell), 32'd1);
        check("ones_min",    32'(pulses >= 4), 32'd1);
        check("ones_cnt",    32'(err_cnt_a), 32'(5 + pulses));
        beats = 0;
        for (int j = 1; j <= 100 && !locked_a; j++) begin
            clean_beat(1'b0, 1'b0);
            beats = j;
        end
        check("relock_beats", 32'(beats), 32'd24);

        // 5. Stuck at zero: all-zero history forces resync.
        fell = 0;
        for (int j = 0; j < 12 && !fell; j++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (!locked_a) fell = 1;
        end
        check("zeros_unlock", 32'(fell), 32'd1);

        // 6a. Sparse valid: lock still after 24 valid beats.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        valid_beats = 0; lock_beat = 0;
        for (int j = 0; j < 400 && lock_beat == 0; j++) begin
            if ($urandom_range(1, 0) == 1) begin
                clean_beat(1'b0, 1'b0);
                valid_beats++;
            end else begin
                step(1'b0, 1'b0, 1'($urandom), 1'b0);
            end
            if (locked_a) lock_beat = valid_beats;
        end
        check("sparse_lock", 32'(lock_beat), 32'd24);

        // 6b. Twenty forced errors: wide counter 20, narrow counter saturates at 15.
        clean_beat(1'b0, 1'b1);
        for (int f = 0; f < 4; f++) begin
            clean_beat(1'b1, 1'b0);
            repeat (11) clean_beat(1'b0, 1'b0);
        end
        check("sat_cnt_a", 32'(err_cnt_a), 32'd20);
        check("sat_cnt_b", 32'(err_cnt_b), 32'd15);
        check("sat_locked", 32'(locked_a), 32'd1);

        // 6c. Clear coinciding with a counted error leaves one.
        clean_beat(1'b0, 1'b1);
        clean_beat(1'b1, 1'b0);
        repeat (3) clean_beat(1'b0, 1'b0);
        clean_beat(1'b0, 1'b1);
        check("clr_hit_cnt", 32'(err_cnt_a), 32'd1);
        repeat (10) clean_beat(1'b0, 1'b0);
        check("clr_tail_cnt", 32'(err_cnt_a), 32'd4);

        // 6d. Reset pulse while locked, with an error pending on that beat.
        clean_beat(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'($urandom), 1'b0);
        check("res_locked", 32'(locked_a),    32'd0);
        check("res_pulse",  32'(err_pulse_a), 32'd0);
        check("res_cnt",    32'(err_cnt_a),   32'd0);

        // Random traffic against the model.
        for (int j = 0; j < 4000; j++) begin
            logic v, b, r, c;
            v = ($urandom_range(3, 0) != 0);
            r = ($urandom_range(1499, 0) == 0);
            c = ($urandom_range(63, 0) == 0);
            if (v) begin
                gen_next(b);
                b = b ^ ($urandom_range(149, 0) == 0);
            end else begin
                b = 1'($urandom);
            end
            step(r, v, b, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
